// File: rtl/mips_mem_responder_if.sv
// -----------------------------------------------------------------------------
// mips_mem_responder_if
// Request/response bundle between the MIPS core's load/store path and the
// data-memory responder.
//   req   core -> mem  request valid, held high until ready
//   we    core -> mem  1 = store word, 0 = load word
//   addr  core -> mem  byte address
//   wdata core -> mem  store data
//   rdata mem -> core  load data, non-zero only in a successful read response
//   ready mem -> core  one-cycle response strobe
//   err   mem -> core  qualifies ready: access rejected (misaligned/out of range)
//   busy  mem -> core  high from request capture through the ready cycle
// -----------------------------------------------------------------------------
interface mips_mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (output req, we, addr, wdata, input rdata, ready, err, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ready, err, busy);
endinterface

// File: rtl/mips_mem_responder.sv
// -----------------------------------------------------------------------------
// mips_mem_responder
// Word-organised data memory that answers one load/store at a time after WAIT
// wait states. Misaligned or out-of-range accesses are answered with err=1,
// never touch the RAM and return rdata=0.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset (aborts any transaction in flight)
//   bus    slave side of mips_mem_responder_if (req/we/addr/wdata in,
//          rdata/ready/err/busy out, all outputs registered)
// Parameters:
//   DEPTH  number of 32-bit words (power of two, >= 2)
//   WAIT   wait-state cycles between capture and response (0..15)
// -----------------------------------------------------------------------------
module mips_mem_responder #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  mips_mem_responder_if.slave         bus
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_err;
  logic        r_busy;
  logic [31:0] r_mem [DEPTH];

  logic             w_start;
  logic             w_fire;
  logic             w_we;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic             w_bad;
  logic [IDX_W-1:0] w_idx;

  assign w_start = (r_state == S_IDLE) && bus.req;

  // With WAIT=0 the response is produced on the capture edge itself, so the
  // live bus values are used there instead of the not-yet-loaded registers.
  assign w_we    = w_start ? bus.we    : r_we;
  assign w_addr  = w_start ? bus.addr  : r_addr;
  assign w_wdata = w_start ? bus.wdata : r_wdata;

  // Edge that moves the FSM into RESP: RAM write and read data happen here.
  assign w_fire = (w_start && (WAIT == 0)) || ((r_state == S_WAIT) && (r_cnt == 4'd1));

  assign w_idx = w_addr[IDX_W+1:2];
  assign w_bad = (w_addr[1:0] != 2'b00) || ((w_addr[31:2] >> IDX_W) != 30'd0);

  // NOTE: the RAM array is deliberately not reset; only the write enable is
  // gated by reset so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (reset && w_fire && w_we && !w_bad) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      // Response outputs are strobes: cleared unless this edge enters RESP.
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;

      unique case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_busy  <= 1'b1;
            r_cnt   <= 4'(WAIT);
            r_state <= (WAIT == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_fire) begin
        r_ready <= 1'b1;
        r_err   <= w_bad;
        r_rdata <= (!w_we && !w_bad) ? r_mem[w_idx] : 32'd0;
        r_cnt   <= 4'd0;
      end
    end
  end

  assign bus.ready = r_ready;
  assign bus.err   = r_err;
  assign bus.busy  = r_busy;
  assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_mips_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mips_mem_responder
// Two responders (WAIT=2 and WAIT=0, DEPTH=64) share one stimulus driver; sel
// routes req to one of them and muxes its outputs back. A transaction-level
// model (capture edge + fixed latency + word array) predicts busy/ready/err/
// rdata every cycle; directed transactions also pin literal results.
// -----------------------------------------------------------------------------
module tb_mips_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, sel;
  logic [31:0] addr, wdata;

  mips_mem_responder_if bus0 ();
  mips_mem_responder_if bus1 ();

  assign bus0.req = req & ~sel;
  assign bus1.req = req & sel;
  assign bus0.we = we;       assign bus1.we = we;
  assign bus0.addr = addr;   assign bus1.addr = addr;
  assign bus0.wdata = wdata; assign bus1.wdata = wdata;

  logic        rdy_o, err_o, busy_o;
  logic [31:0] rdata_o;
  assign rdy_o   = sel ? bus1.ready : bus0.ready;
  assign err_o   = sel ? bus1.err   : bus0.err;
  assign busy_o  = sel ? bus1.busy  : bus0.busy;
  assign rdata_o = sel ? bus1.rdata : bus0.rdata;

  mips_mem_responder #(.DEPTH(64), .WAIT(2)) u_dut_w2 (.clk(clk), .reset(reset), .bus(bus0));
  mips_mem_responder #(.DEPTH(64), .WAIT(0)) u_dut_w0 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] mm [2][64];
  int unsigned cyc = 0;
  int unsigned cap;
  bit          act = 0;
  bit          m_we, m_bad;
  logic [31:0] m_addr, m_wd;
  bit          e_busy = 0, e_ready = 0, e_err = 0;
  logic [31:0] e_rdata = 0;

  always @(posedge clk) begin
    int unsigned lat;
    lat = sel ? 0 : 2;
    cyc++;
    if (!reset) begin
      act = 0;
    end else if (!act) begin
      if (req) begin
        act = 1; cap = cyc; m_we = we; m_addr = addr; m_wd = wdata;
      end
    end else if (cyc == cap + lat + 1) begin
      act = 0;
    end
    m_bad   = (m_addr[1:0] != 2'b00) || (m_addr >= 32'd256);
    e_busy  = act;
    e_ready = act && (cyc == cap + lat);
    e_err   = e_ready && m_bad;
    e_rdata = 32'd0;
    if (e_ready && !m_bad) begin
      if (m_we) mm[sel][m_addr[7:2]] = m_wd;
      else      e_rdata = mm[sel][m_addr[7:2]];
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("busy",  {31'd0, busy_o}, {31'd0, e_busy});
      check("ready", {31'd0, rdy_o},  {31'd0, e_ready});
      check("err",   {31'd0, err_o},  {31'd0, e_err});
      check("rdata", rdata_o, e_rdata);
    end
  end

  // ---------------- driver ----------------
  // Call right after a rising edge. lat = cycles from the capture edge to the
  // cycle in which ready is seen (1 => the cycle right after capture).
  // mode: 0 hold inputs, 1 switch addr to alt after capture, 2 scramble inputs.
  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int mode, input logic [31:0] alt,
                      output logic [31:0] rd, output bit e, output int lat);
    req = 1'b1; we = w; addr = a; wdata = d;
    lat = 0; rd = 32'd0; e = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rdy_o) begin
        lat = i - 1; rd = rdata_o; e = err_o;
        break;
      end
      if (i >= 2 && mode == 1) addr = alt;
      if (i >= 2 && mode == 2) begin
        addr = $urandom; wdata = $urandom; we = 1'($urandom);
      end
    end
    if (lat == 0) check("ready_timeout", {31'd0, rdy_o}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  logic [31:0] rd;
  bit          e;
  int          lat;
  int          rdy_seen;

  initial begin
    reset = 1'b0; req = 1'b0; we = 1'b0; sel = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, rdy_o}, 32'd0);
    check("rst_busy",  {31'd0, busy_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Fill both RAMs with a known pattern.
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int i = 0; i < 64; i++) xact(1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), 0, 0, rd, e, lat);
      @(posedge clk); #1;
    end

    // WAIT=2 directed cases.
    sel = 1'b0;
    xact(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 0, rd, e, lat);
    check("w2_wr_lat", 32'(lat), 32'd3);
    check("w2_wr_err", {31'd0, e}, 32'd0);
    xact(1'b0, 32'h10, 32'd0, 0, 0, rd, e, lat);
    check("w2_rd_lat", 32'(lat), 32'd3);
    check("w2_rd_data", rd, 32'hDEAD_BEEF);
    check("w2_rd_err", {31'd0, e}, 32'd0);
    xact(1'b1, 32'h11, 32'hFFFF_FFFF, 0, 0, rd, e, lat);
    check("misalign_err", {31'd0, e}, 32'd1);
    xact(1'b0, 32'h10, 32'd0, 0, 0, rd, e, lat);
    check("misalign_keep", rd, 32'hDEAD_BEEF);
    xact(1'b0, 32'h100, 32'd0, 0, 0, rd, e, lat);
    check("oor_rd_err", {31'd0, e}, 32'd1);
    check("oor_rd_data", rd, 32'd0);
    xact(1'b1, 32'h100, 32'h1234_0000, 0, 0, rd, e, lat);
    check("oor_wr_err", {31'd0, e}, 32'd1);
    xact(1'b0, 32'h0, 32'd0, 0, 0, rd, e, lat);
    check("oor_word0", rd, 32'hA500_0000);
    xact(1'b0, 32'h10, 32'd0, 1, 32'h04, rd, e, lat);
    check("busy_ignore", rd, 32'hDEAD_BEEF);

    // Reset in the middle of a store.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; addr = 32'h08; wdata = 32'h0000_AAAA;
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy_in", {31'd0, busy_o}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy_out", {31'd0, busy_o}, 32'd0);
    reset = 1'b1; req = 1'b0;
    rdy_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy_o) rdy_seen++;
    end
    check("midrst_no_ready", 32'(rdy_seen), 32'd0);
    @(posedge clk); #1;
    xact(1'b0, 32'h08, 32'd0, 0, 0, rd, e, lat);
    check("midrst_prior", rd, 32'hA500_0002);

    // WAIT=0 directed cases.
    @(posedge clk); #1;
    sel = 1'b1;
    xact(1'b1, 32'h04, 32'h1234_5678, 0, 0, rd, e, lat);
    check("w0_wr_lat", 32'(lat), 32'd1);
    xact(1'b0, 32'h04, 32'd0, 0, 0, rd, e, lat);
    check("w0_rd_lat", 32'(lat), 32'd1);
    check("w0_rd_data", rd, 32'h1234_5678);

    // Random traffic on both instances, back-to-back or with gaps.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int          kind;
      if (n % 50 == 0) begin
        @(posedge clk); #1;
        sel = 1'($urandom);
      end
      kind = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 63)) << 2;
      if (kind == 8) a = a | 32'($urandom_range(1, 3));
      if (kind == 9) a = $urandom;
      xact(1'($urandom), a, $urandom, 2, 0, rd, e, lat);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
